// File: rtl/pulse_pacer_pkg.sv
// Shared types and defaults for the pulse pacer CDC front end.
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GAP      = 2'd1,
    ST_WAIT_ACK = 2'd2
  } pacer_state_t;

  localparam int PACER_GAP_DEF   = 8;
  localparam int PACER_CNT_W_DEF = 4;

endpackage

// File: rtl/pulse_pacer_sync_2ff.sv
// Single-bit two-flop synchroniser, synchronous active-high reset to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // metastability capture stage followed by the settled stage
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pulse_pacer.sv
// Paces bursty source-domain events into single-cycle pulses spaced >= GAP cycles.
// Optional macro PULSE_PACER_ACK_EN: also waits for a toggle ack from the dst domain.
module pulse_pacer
  import pulse_pkg::*;
#(
  parameter int GAP   = PACER_GAP_DEF,
  parameter int CNT_W = PACER_CNT_W_DEF
) (
  input  logic             clk_src,
  input  logic             reset,
  input  logic             event_in,
  input  logic             clear_ovf,
  input  logic             ack_tgl,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             busy
);

  localparam int GW = $clog2(GAP);
  localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP - 1);
  localparam logic [GW-1:0]    GAP_ZERO = {GW{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  pacer_state_t     r_state;
  pacer_state_t     w_state_nxt;
  logic [GW-1:0]    r_gap_cnt;
  logic [GW-1:0]    w_gap_nxt;
  logic [CNT_W-1:0] r_pending;
  logic [CNT_W-1:0] w_pending_nxt;
  logic             r_overflow;
  logic             w_overflow_nxt;
  logic             r_pulse;
  logic             w_emit;
  logic             w_drop;
  logic             w_has_pend;
  logic             w_gap_release;
  logic             w_ack_release;

`ifdef PULSE_PACER_ACK_EN
  logic w_ack_sync;
  logic r_ack_sync_d;
  logic w_ack_seen;
  logic r_ack_flag;

  sync_2ff u_ack_sync (
    .i_clk   (clk_src),
    .i_reset (reset),
    .i_d     (ack_tgl),
    .o_q     (w_ack_sync)
  );

  // edge detect on the synchronised toggle, plus an ack remembered during GAP
  always_ff @(posedge clk_src) begin
    if (reset) begin
      r_ack_sync_d <= 1'b0;
      r_ack_flag   <= 1'b0;
    end else begin
      r_ack_sync_d <= w_ack_sync;
      if (w_emit) begin
        r_ack_flag <= 1'b0;
      end else if ((r_state == ST_GAP) && w_ack_seen) begin
        r_ack_flag <= 1'b1;
      end else begin
        r_ack_flag <= r_ack_flag;
      end
    end
  end

  assign w_ack_seen    = w_ack_sync ^ r_ack_sync_d;
  assign w_gap_release = r_ack_flag | w_ack_seen;
  assign w_ack_release = w_ack_seen;
`else
  logic w_unused_ack;
  assign w_unused_ack  = ack_tgl;
  assign w_gap_release = 1'b1;
  assign w_ack_release = 1'b1;
`endif

  assign w_has_pend = (r_pending != CNT_ZERO);

  // state, gap counter and registered outputs
  always_ff @(posedge clk_src) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_gap_cnt  <= GAP_ZERO;
      r_pending  <= CNT_ZERO;
      r_overflow <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_pending  <= w_pending_nxt;
      r_overflow <= w_overflow_nxt;
      r_pulse    <= w_emit;
    end
  end

  // next-state and emit decision
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_has_pend) begin
          w_emit      = 1'b1;
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt != GAP_ZERO) begin
          w_state_nxt = ST_GAP;
        end else if (!w_gap_release) begin
          w_state_nxt = ST_WAIT_ACK;
        end else if (w_has_pend) begin
          w_emit      = 1'b1;
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (!w_ack_release) begin
          w_state_nxt = ST_WAIT_ACK;
        end else if (w_has_pend) begin
          w_emit      = 1'b1;
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // gap countdown, saturating pending counter and sticky overflow
  always_comb begin
    w_gap_nxt      = r_gap_cnt;
    w_pending_nxt  = r_pending;
    w_overflow_nxt = r_overflow;
    w_drop         = event_in & ~w_emit & (r_pending == CNT_MAX);

    if (w_emit) begin
      w_gap_nxt = GAP_LOAD;
    end else if ((r_state == ST_GAP) && (r_gap_cnt != GAP_ZERO)) begin
      w_gap_nxt = r_gap_cnt - GW'(1);
    end else begin
      w_gap_nxt = r_gap_cnt;
    end

    case ({event_in, w_emit})
      2'b10: begin
        if (r_pending != CNT_MAX) begin
          w_pending_nxt = r_pending + CNT_W'(1);
        end else begin
          w_pending_nxt = r_pending;
        end
      end
      2'b01: begin
        w_pending_nxt = r_pending - CNT_W'(1);
      end
      default: begin
        w_pending_nxt = r_pending;
      end
    endcase

    // a drop in the same cycle as a clear keeps the flag set
    if (w_drop) begin
      w_overflow_nxt = 1'b1;
    end else if (clear_ovf) begin
      w_overflow_nxt = 1'b0;
    end else begin
      w_overflow_nxt = r_overflow;
    end
  end

  assign pulse_out = r_pulse;
  assign pending   = r_pending;
  assign overflow  = r_overflow;
  assign busy      = (r_state != ST_IDLE) | w_has_pend;

endmodule

// File: tb/tb_pulse_pacer.sv
// Directed bench for pulse_pacer: per-cycle vector table plus hand-written corner sequences.
module tb_pulse_pacer;

  logic       clk_src = 1'b0;
  logic       reset;
  logic       ev_a, clr_a, ack_a;
  logic       ev_b, clr_b, ack_b;
  logic       pulse_a, ovf_a, busy_a;
  logic [3:0] pend_a;
  logic       pulse_b, ovf_b, busy_b;
  logic [1:0] pend_b;

  int checks   = 0;
  int failures = 0;
  bit auto_ack = 1'b1;

  always #5 clk_src = ~clk_src;

  pulse_pacer #(.GAP(8), .CNT_W(4)) u_dut_a (
    .clk_src(clk_src), .reset(reset), .event_in(ev_a), .clear_ovf(clr_a), .ack_tgl(ack_a),
    .pulse_out(pulse_a), .pending(pend_a), .overflow(ovf_a), .busy(busy_a)
  );

  pulse_pacer #(.GAP(8), .CNT_W(2)) u_dut_b (
    .clk_src(clk_src), .reset(reset), .event_in(ev_b), .clear_ovf(clr_b), .ack_tgl(ack_b),
    .pulse_out(pulse_b), .pending(pend_b), .overflow(ovf_b), .busy(busy_b)
  );

  typedef struct {
    logic       ev;
    logic       clr;
    logic       pulse;
    logic [3:0] pend;
    logic       ovf;
    logic       busy;
    string      name;
  } vec_t;

  vec_t tbl[$];

  // Stand-in for the destination domain: toggles the ack after each received pulse.
  always @(posedge clk_src) begin
    #1;
    if (auto_ack && pulse_a === 1'b1) ack_a = ~ack_a;
    if (auto_ack && pulse_b === 1'b1) ack_b = ~ack_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_src);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    ev_a = 1'b0; clr_a = 1'b0; ev_b = 1'b0; clr_b = 1'b0;
    step();
    step();
    check({tag, "_rst_pulse_a"}, 32'(pulse_a), 32'd0);
    check({tag, "_rst_pend_a"},  32'(pend_a),  32'd0);
    check({tag, "_rst_ovf_a"},   32'(ovf_a),   32'd0);
    check({tag, "_rst_busy_a"},  32'(busy_a),  32'd0);
    check({tag, "_rst_pend_b"},  32'(pend_b),  32'd0);
    reset = 1'b0;
  endtask

  function automatic void add(input logic ev, input logic clr, input logic pulse,
                              input logic [3:0] pend, input logic ovf, input logic busy,
                              input string name);
    vec_t v;
    v.ev = ev; v.clr = clr; v.pulse = pulse; v.pend = pend; v.ovf = ovf; v.busy = busy; v.name = name;
    tbl.push_back(v);
  endfunction

  initial begin
    int cnt;
    int maxp;
    int lat;
    bit saw_ovf;
    int pos[$];

    ack_a = 1'b0;
    ack_b = 1'b0;

    // single event, then an event landing on an emit cycle
    add(1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, "t1_ev");
    add(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, "t1_emit");
    for (int i = 0; i < 7; i++) add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "t1_gap");
    add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "t1_idle");
    add(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "t1_clr_idle");
    add(1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, "t4_ev1");
    add(1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, "t4_ev_on_emit");
    for (int i = 0; i < 7; i++) add(1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, "t4_gap");
    add(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, "t4_emit2");
    for (int i = 0; i < 7; i++) add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "t4_gap2");
    add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "t4_idle");

    do_reset("t1");
    for (int i = 0; i < tbl.size(); i++) begin
      ev_a  = tbl[i].ev;
      clr_a = tbl[i].clr;
      step();
      check({tbl[i].name, "_pulse"}, 32'(pulse_a), 32'(tbl[i].pulse));
      check({tbl[i].name, "_pend"},  32'(pend_a),  32'(tbl[i].pend));
      check({tbl[i].name, "_ovf"},   32'(ovf_a),   32'(tbl[i].ovf));
      check({tbl[i].name, "_busy"},  32'(busy_a),  32'(tbl[i].busy));
    end
    ev_a = 1'b0; clr_a = 1'b0;

    // burst of 5: emits on relative edges 1, 9, 17, 25, 33
    do_reset("t2");
    saw_ovf = 1'b0;
    for (int i = 0; i < 60; i++) begin
      ev_a = (i < 5);
      step();
      if (pulse_a === 1'b1) pos.push_back(i);
      if (ovf_a !== 1'b0) saw_ovf = 1'b1;
    end
    ev_a = 1'b0;
    check("t2_pulse_count", 32'(pos.size()), 32'd5);
    if (pos.size() > 0) check("t2_first_latency", 32'(pos[0]), 32'd1);
    for (int k = 1; k < pos.size(); k++) check("t2_spacing", 32'(pos[k] - pos[k-1]), 32'd8);
    check("t2_no_overflow", 32'(saw_ovf), 32'd0);
    check("t2_pend_end", 32'(pend_a), 32'd0);
    check("t2_busy_end", 32'(busy_a), 32'd0);

    // saturation on the CNT_W=2 instance, clear_ovf colliding with a drop
    do_reset("t3");
    cnt = 0;
    maxp = 0;
    for (int i = 0; i < 50; i++) begin
      ev_b  = (i < 10);
      clr_b = (i == 5);
      step();
      if (pulse_b === 1'b1) cnt++;
      if (int'(pend_b) > maxp) maxp = int'(pend_b);
      if (i == 3) begin
        check("t3_pend_full", 32'(pend_b), 32'd3);
        check("t3_ovf_before_drop", 32'(ovf_b), 32'd0);
      end
      if (i == 5) check("t3_clr_vs_drop", 32'(ovf_b), 32'd1);
    end
    ev_b = 1'b0; clr_b = 1'b0;
    check("t3_pend_max", 32'(maxp), 32'd3);
    check("t3_pulse_count", 32'(cnt), 32'd5);
    check("t3_ovf_sticky", 32'(ovf_b), 32'd1);
    check("t3_pend_end", 32'(pend_b), 32'd0);
    clr_b = 1'b1;
    step();
    clr_b = 1'b0;
    check("t3_ovf_cleared", 32'(ovf_b), 32'd0);

    // reset in the middle of a burst discards the queue
    do_reset("t5");
    for (int i = 0; i < 4; i++) begin
      ev_a = 1'b1;
      step();
    end
    ev_a = 1'b0;
    check("t5_pend_pre", 32'(pend_a), 32'd3);
    check("t5_busy_pre", 32'(busy_a), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_pend_post", 32'(pend_a), 32'd0);
    check("t5_pulse_post", 32'(pulse_a), 32'd0);
    check("t5_busy_post", 32'(busy_a), 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pulse_a === 1'b1) cnt++;
    end
    check("t5_no_pulses", 32'(cnt), 32'd0);

    auto_ack = 1'b0;
    ack_a = 1'b0;
    do_reset("t6");
    cnt = 0;
    ev_a = 1'b1;
    step();
    step();
    ev_a = 1'b0;
    if (pulse_a === 1'b1) cnt++;
`ifdef PULSE_PACER_ACK_EN
    // ack withheld: only one pulse in flight
    for (int i = 0; i < 30; i++) begin
      step();
      if (pulse_a === 1'b1) cnt++;
    end
    check("t6_one_pulse", 32'(cnt), 32'd1);
    check("t6_busy_wait", 32'(busy_a), 32'd1);
    check("t6_pend_wait", 32'(pend_a), 32'd1);
    ack_a = ~ack_a;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (pulse_a === 1'b1 && lat < 0) lat = k;
    end
    check("t6_ack_latency_3to4", 32'((lat >= 3) && (lat <= 4)), 32'd1);
    check("t6_pend_done", 32'(pend_a), 32'd0);
`else
    // without the ack feature, ack_tgl is ignored and both events are paced out
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pulse_a === 1'b1) begin
        cnt++;
        if (lat < 0) lat = i + 1;
      end
    end
    check("t6_no_ack_pulses", 32'(cnt), 32'd2);
    check("t6_no_ack_spacing", 32'(lat), 32'd8);
    check("t6_no_ack_pend", 32'(pend_a), 32'd0);
`endif
    auto_ack = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
